// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues a word read at the current PC, waits for memory, latches the
// instruction for decode and pulses inc_pc once per fetch that reaches decode.
module instruction_fetch_unit #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic [31:0]       pc_in,
  output logic              inc_pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [31:0]       mem_data_in,
  input  logic              mem_ready,
  output logic [31:0]       ir_out,
  output logic [31:0]       ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t              state_q;
  logic [31:0]         fetch_pc_q;
  logic [7:0]          wait_cnt_q;
  logic [7:0]          wait_cnt_d;
  logic                drop_q;
  logic                inc_pc_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_read_q;
  logic [31:0]         ir_out_q;
  logic [31:0]         ir_pc_q;
  logic                ir_valid_q;
  logic                fetch_err_q;
  logic                start_fetch;
  logic                wait_expired;
  logic                discard_resp;

  assign wait_cnt_d   = wait_cnt_q + 8'd1;
  assign start_fetch  = fetch_en && !flush;
  assign wait_expired = (wait_cnt_q == WAIT_LAST);
  // A flush seen earlier in this WAIT, or arriving with the response, kills the data.
  assign discard_resp = drop_q || flush;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= ST_ISSUE;
      fetch_pc_q  <= 32'd0;
      wait_cnt_q  <= 8'd0;
      drop_q      <= 1'b0;
      inc_pc_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_read_q  <= 1'b0;
      ir_out_q    <= 32'd0;
      ir_pc_q     <= 32'd0;
      ir_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      inc_pc_q <= 1'b0;
      case (state_q)
        ST_ISSUE: begin
          if (start_fetch) begin
            mem_addr_q <= pc_in[ADDR_W-1:0];
            fetch_pc_q <= pc_in;
            mem_read_q <= 1'b1;
            wait_cnt_q <= 8'd0;
            drop_q     <= 1'b0;
            state_q    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (mem_ready) begin
            mem_read_q <= 1'b0;
            if (discard_resp) begin
              state_q <= ST_ISSUE;
            end else begin
              ir_out_q   <= mem_data_in;
              ir_pc_q    <= fetch_pc_q;
              ir_valid_q <= 1'b1;
              inc_pc_q   <= 1'b1;
              state_q    <= ST_HOLD;
            end
          end else begin
            // The read is never abandoned on flush; only its data is dropped later.
            if (flush) begin
              drop_q <= 1'b1;
            end
            if (wait_expired) begin
              fetch_err_q <= 1'b1;
              mem_read_q  <= 1'b0;
              state_q     <= ST_HALT;
            end else begin
              wait_cnt_q <= wait_cnt_d;
            end
          end
        end

        ST_HOLD: begin
          if (flush || ir_ready) begin
            ir_valid_q <= 1'b0;
            state_q    <= ST_ISSUE;
          end
        end

        ST_HALT: begin
          ir_valid_q <= 1'b0;
        end

        default: begin
          state_q <= ST_ISSUE;
        end
      endcase
    end
  end

  assign inc_pc    = inc_pc_q;
  assign mem_addr  = mem_addr_q;
  assign mem_read  = mem_read_q;
  assign ir_out    = ir_out_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cycle table, directed corner sequences and a
// randomized run checked against an in-order fetch stream model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        clr;
  logic        fetch_en;
  logic        flush;
  logic [31:0] pc_in;
  logic        inc_pc;
  logic [8:0]  mem_addr;
  logic        mem_read;
  logic [31:0] mem_data_in;
  logic        mem_ready;
  logic [31:0] ir_out;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        fetch_err;

  instruction_fetch_unit #(.ADDR_W(9), .TIMEOUT(16)) dut (
    .clk(clk), .clr(clr), .fetch_en(fetch_en), .flush(flush), .pc_in(pc_in),
    .inc_pc(inc_pc), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready), .ir_out(ir_out),
    .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        fe;
    logic        fl;
    logic [31:0] pc;
    logic        mr;
    logic [31:0] md;
    logic        rdy;
    logic        e_inc;
    logic [8:0]  e_addr;
    logic        e_mr;
    logic        e_iv;
    logic [31:0] e_ir;
    logic [31:0] e_irpc;
    logic        e_err;
  } vec_t;

  vec_t vecs [10];

  // random-phase model state
  logic [31:0] pc_model, base_pc, exp_pc, prev_ir, prev_irpc;
  logic [8:0]  prev_addr;
  int          n_cons, n_inc, gap, mem_lat;
  logic        pend_inc, mem_busy, prev_wait, prev_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic fe, input logic fl, input logic [31:0] pc,
                              input logic mr, input logic [31:0] md, input logic rdy,
                              input logic e_inc, input logic [8:0] e_addr, input logic e_mr,
                              input logic e_iv, input logic [31:0] e_ir,
                              input logic [31:0] e_irpc, input logic e_err);
    vec_t v;
    v.fe = fe; v.fl = fl; v.pc = pc; v.mr = mr; v.md = md; v.rdy = rdy;
    v.e_inc = e_inc; v.e_addr = e_addr; v.e_mr = e_mr; v.e_iv = e_iv;
    v.e_ir = e_ir; v.e_irpc = e_irpc; v.e_err = e_err;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [8:0] a);
    return {a, 23'd0} ^ (32'h9E3779B9 * {23'd0, a}) ^ 32'h5A5A0000;
  endfunction

  task automatic drive_idle();
    fetch_en = 1'b0; flush = 1'b0; pc_in = 32'd0;
    mem_ready = 1'b0; mem_data_in = 32'd0; ir_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_inc"}, {31'd0, inc_pc}, 32'd0);
    chk({tag, "_addr"}, {23'd0, mem_addr}, 32'd0);
    chk({tag, "_mread"}, {31'd0, mem_read}, 32'd0);
    chk({tag, "_ir"}, ir_out, 32'd0);
    chk({tag, "_irpc"}, ir_pc, 32'd0);
    chk({tag, "_iv"}, {31'd0, ir_valid}, 32'd0);
    chk({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
  endtask

  task automatic do_reset();
    drive_idle();
    clr = 1'b0;
    @(negedge clk);
    check_all_zero("rst");
    @(negedge clk);
    clr = 1'b1;
    step();
  endtask

  task automatic rand_cycle(input bit allow_fetch);
    if (inc_pc) begin
      if (n_inc > 0) chk("inc_gap", (gap >= 2) ? 32'd1 : 32'd0, 32'd1);
      n_inc++;
      gap = 0;
    end else begin
      gap++;
    end
    if (prev_wait) begin
      chk("addr_stable", {23'd0, mem_addr}, {23'd0, prev_addr});
      chk("read_held", {31'd0, mem_read}, 32'd1);
    end
    if (prev_hold) begin
      chk("ir_stable", ir_out, prev_ir);
      chk("irpc_stable", ir_pc, prev_irpc);
      chk("valid_held", {31'd0, ir_valid}, 32'd1);
    end
    if (pend_inc) pc_model = pc_model + 32'd1;
    pend_inc = inc_pc;
    pc_in    = pc_model;
    fetch_en = allow_fetch && ($urandom_range(0, 4) != 0);
    ir_ready = allow_fetch ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (mem_read) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_lat  = int'($urandom_range(0, 3));
      end
      if (mem_lat == 0) begin
        mem_ready   = 1'b1;
        mem_data_in = mem_word(mem_addr);
        mem_busy    = 1'b0;
      end else begin
        mem_lat--;
        mem_ready   = 1'b0;
        mem_data_in = $urandom;
      end
    end else begin
      mem_ready = 1'b0;
      mem_busy  = 1'b0;
    end
    prev_wait = mem_read && !mem_ready;
    prev_addr = mem_addr;
    prev_hold = ir_valid && !ir_ready;
    prev_ir   = ir_out;
    prev_irpc = ir_pc;
    if (ir_valid && ir_ready) begin
      exp_pc = base_pc + 32'(n_cons);
      chk("ir_pc", ir_pc, exp_pc);
      chk("ir_out", ir_out, mem_word(exp_pc[8:0]));
      n_cons++;
    end
    step();
  endtask

  initial begin
    int mr_cnt, iv_cnt, inc_cnt;
    clr = 1'b1;
    drive_idle();
    #2;

    // ---- cycle table: zero-wait fetch, PC advance, HOLD backpressure and flush ----
    vecs[0] = mk(1, 0, 32'h10, 0, 32'h0,        0,  0, 9'h010, 1, 0, 32'h0,        32'h0,  0);
    vecs[1] = mk(1, 0, 32'h10, 1, 32'hDEADBEEF, 1,  1, 9'h010, 0, 1, 32'hDEADBEEF, 32'h10, 0);
    vecs[2] = mk(1, 0, 32'h10, 0, 32'h0,        1,  0, 9'h010, 0, 0, 32'hDEADBEEF, 32'h10, 0);
    vecs[3] = mk(1, 0, 32'h11, 0, 32'h0,        0,  0, 9'h011, 1, 0, 32'hDEADBEEF, 32'h10, 0);
    vecs[4] = mk(1, 0, 32'h11, 1, 32'h12345678, 0,  1, 9'h011, 0, 1, 32'h12345678, 32'h11, 0);
    vecs[5] = mk(1, 0, 32'h11, 0, 32'h0,        0,  0, 9'h011, 0, 1, 32'h12345678, 32'h11, 0);
    vecs[6] = mk(1, 1, 32'h80, 0, 32'h0,        1,  0, 9'h011, 0, 0, 32'h12345678, 32'h11, 0);
    vecs[7] = mk(0, 0, 32'h80, 0, 32'h0,        0,  0, 9'h011, 0, 0, 32'h12345678, 32'h11, 0);
    vecs[8] = mk(1, 1, 32'h80, 0, 32'h0,        0,  0, 9'h011, 0, 0, 32'h12345678, 32'h11, 0);
    vecs[9] = mk(1, 0, 32'h80, 0, 32'h0,        0,  0, 9'h080, 1, 0, 32'h12345678, 32'h11, 0);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      fetch_en = vecs[i].fe; flush = vecs[i].fl; pc_in = vecs[i].pc;
      mem_ready = vecs[i].mr; mem_data_in = vecs[i].md; ir_ready = vecs[i].rdy;
      step();
      chk($sformatf("v%0d_inc", i), {31'd0, inc_pc}, {31'd0, vecs[i].e_inc});
      chk($sformatf("v%0d_addr", i), {23'd0, mem_addr}, {23'd0, vecs[i].e_addr});
      chk($sformatf("v%0d_mread", i), {31'd0, mem_read}, {31'd0, vecs[i].e_mr});
      chk($sformatf("v%0d_iv", i), {31'd0, ir_valid}, {31'd0, vecs[i].e_iv});
      chk($sformatf("v%0d_ir", i), ir_out, vecs[i].e_ir);
      chk($sformatf("v%0d_irpc", i), ir_pc, vecs[i].e_irpc);
      chk($sformatf("v%0d_err", i), {31'd0, fetch_err}, {31'd0, vecs[i].e_err});
    end

    // ---- async reset between edges while in WAIT, then restart ----
    #3;
    clr = 1'b0;
    #1;
    check_all_zero("async_wait");
    @(negedge clk);
    clr = 1'b1;
    drive_idle();
    fetch_en = 1'b1; pc_in = 32'h55;
    step();
    chk("restart_addr", {23'd0, mem_addr}, 32'h055);
    chk("restart_mread", {31'd0, mem_read}, 32'd1);

    // ---- wait states and decode backpressure ----
    do_reset();
    fetch_en = 1'b1; pc_in = 32'h33;
    step();
    fetch_en = 1'b0;
    mr_cnt = 0; iv_cnt = 0; inc_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (mem_read) begin
        mr_cnt++;
        chk("bp_addr", {23'd0, mem_addr}, 32'h033);
      end
      if (ir_valid) begin
        iv_cnt++;
        chk("bp_ir", ir_out, 32'hCAFE0033);
      end
      if (inc_pc) inc_cnt++;
      mem_ready   = (c == 3);
      mem_data_in = (c == 3) ? 32'hCAFE0033 : $urandom;
      ir_ready    = (iv_cnt == 4);
      step();
    end
    chk("bp_mread_cycles", 32'(mr_cnt), 32'd4);
    chk("bp_valid_cycles", 32'(iv_cnt), 32'd4);
    chk("bp_inc_pulses", 32'(inc_cnt), 32'd1);

    // ---- flush in WAIT one cycle before the response ----
    do_reset();
    fetch_en = 1'b1; pc_in = 32'h30;
    step();
    fetch_en = 1'b0;
    chk("fw_addr", {23'd0, mem_addr}, 32'h030);
    step();
    flush = 1'b1; pc_in = 32'h40;
    step();
    chk("fw_inc0", {31'd0, inc_pc}, 32'd0);
    flush = 1'b0; mem_ready = 1'b1; mem_data_in = 32'hBADBAD00; fetch_en = 1'b1;
    step();
    chk("fw_inc1", {31'd0, inc_pc}, 32'd0);
    chk("fw_iv", {31'd0, ir_valid}, 32'd0);
    chk("fw_mread", {31'd0, mem_read}, 32'd0);
    mem_ready = 1'b0;
    step();
    chk("fw_new_addr", {23'd0, mem_addr}, 32'h040);
    chk("fw_new_mread", {31'd0, mem_read}, 32'd1);
    chk("fw_inc2", {31'd0, inc_pc}, 32'd0);
    fetch_en = 1'b0; mem_ready = 1'b1; mem_data_in = 32'h0B0B0040;
    step();
    chk("fw_new_ir", ir_out, 32'h0B0B0040);
    chk("fw_new_irpc", ir_pc, 32'h40);
    chk("fw_new_inc", {31'd0, inc_pc}, 32'd1);

    // ---- memory timeout, HALT ignores flush, reset clears the sticky flag ----
    do_reset();
    fetch_en = 1'b1; pc_in = 32'h20;
    step();
    for (int c = 1; c < 16; c++) begin
      step();
      chk($sformatf("to_mread_%0d", c), {31'd0, mem_read}, 32'd1);
      chk($sformatf("to_err_%0d", c), {31'd0, fetch_err}, 32'd0);
    end
    step();
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_mread", {31'd0, mem_read}, 32'd0);
    flush = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("halt_mread", {31'd0, mem_read}, 32'd0);
      chk("halt_err", {31'd0, fetch_err}, 32'd1);
      chk("halt_inc", {31'd0, inc_pc}, 32'd0);
      chk("halt_addr", {23'd0, mem_addr}, 32'h020);
    end
    #3;
    clr = 1'b0;
    #1;
    chk("halt_rst_err", {31'd0, fetch_err}, 32'd0);
    chk("halt_rst_mread", {31'd0, mem_read}, 32'd0);
    @(negedge clk);
    clr = 1'b1;

    // ---- randomized run against an in-order fetch stream model ----
    do_reset();
    base_pc = $urandom;
    pc_model = base_pc;
    n_cons = 0; n_inc = 0; gap = 100; mem_lat = 0;
    pend_inc = 1'b0; mem_busy = 1'b0; prev_wait = 1'b0; prev_hold = 1'b0;
    prev_ir = 32'd0; prev_irpc = 32'd0; prev_addr = 9'd0;
    for (int c = 0; c < 800; c++) rand_cycle(1'b1);
    for (int c = 0; c < 12; c++) rand_cycle(1'b0);
    chk("rand_progress", (n_cons > 20) ? 32'd1 : 32'd0, 32'd1);
    chk("rand_inc_count", 32'(n_inc), 32'(n_cons));
    chk("rand_err", {31'd0, fetch_err}, 32'd0);
    chk("rand_drained", {31'd0, ir_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly downstream of the program counter. It samples the current PC, issues a word read to instruction memory and waits for the memory's ready response. It then latches the returned word as the instruction register, presents it to decode with a valid/ready handshake, and pulses inc_pc once per accepted fetch so the PC advances. A flush from branch logic discards work in flight, and a wait-timeout guards against a hung memory.

Parameters:
ADDR_W, 9, width of the word address driven to instruction memory; equals pc_in[ADDR_W-1:0].
TIMEOUT, 16, maximum WAIT cycles without mem_ready before fetch_err is raised; legal range 2..255.

Ports:
clk  input  1  system clock; all state changes on rising edge.
clr  input  1  reset, asynchronous, active-low.
fetch_en  input  1  allows a new fetch to start in ISSUE.
flush  input  1  synchronous; PC is being reloaded, so discard any in-flight fetch.
pc_in  input  32  current PC value from the program counter.
inc_pc  output  1  one-cycle pulse requesting a PC increment.
mem_addr  output  ADDR_W  registered memory word address.
mem_read  output  1  registered read request; held until mem_ready.
mem_data_in  input  32  instruction word from memory; valid when mem_ready=1.
mem_ready  input  1  memory response strobe.
ir_out  output  32  instruction register.
ir_pc  output  32  PC value the word in ir_out was fetched from.
ir_valid  output  1  ir_out holds an unconsumed instruction.
ir_ready  input  1  decode accepts ir_out this cycle.
fetch_err  output  1  sticky memory-timeout flag.

Behaviour:
- Reset (clr=0, async): state=ISSUE, drop=0, wait_cnt=0. Every output is 0: inc_pc, mem_addr, mem_read, ir_out, ir_pc, ir_valid, fetch_err.
- All outputs are registered. inc_pc defaults to 0 every cycle unless set below.
- States are ISSUE, WAIT, HOLD and HALT. Internal registers: fetch_pc[31:0], wait_cnt[7:0], drop.
- ISSUE:
  - If flush=1 or fetch_en=0, remain in ISSUE and issue nothing.
  - Otherwise: mem_addr<=pc_in[ADDR_W-1:0], fetch_pc<=pc_in, mem_read<=1, wait_cnt<=0, drop<=0, state<=WAIT.
- WAIT (mem_addr and mem_read held stable):
  - On mem_ready=1:
    - mem_read<=0.
    - If drop=1 or flush=1: discard the data and go to ISSUE; inc_pc stays 0.
    - Else: ir_out<=mem_data_in, ir_pc<=fetch_pc, ir_valid<=1, inc_pc<=1, state<=HOLD.
  - On mem_ready=0:
    - If flush=1, set drop<=1. The outstanding read completes; it is never abandoned.
    - If wait_cnt==TIMEOUT-1: fetch_err<=1, mem_read<=0, state<=HALT.
    - Else wait_cnt<=wait_cnt+1.
- HOLD:
  - ir_valid=1 with ir_out and ir_pc stable.
  - If flush=1: ir_valid<=0, state<=ISSUE. Flush wins over a simultaneous ir_ready.
  - Else if ir_ready=1: ir_valid<=0, state<=ISSUE.
- HALT: all outputs hold except ir_valid<=0. Only clr exits HALT; flush has no effect.
- PC ordering: inc_pc rises on the WAIT->HOLD edge and the PC updates on the following edge. The next ISSUE is at least one cycle after that, so it samples the incremented PC.
- inc_pc is never high on two consecutive cycles; it is always separated by at least 2 low cycles. This satisfies the PC's rearm requirement.
- Latency: the ISSUE edge is cycle 0 and mem_read=1 in cycle 1. With mem_ready=1 in cycle 1, ir_valid=1 and inc_pc=1 in cycle 2.
- Throughput: with zero-wait memory and ir_ready tied high, one instruction every 3 cycles.
- Reset mid-operation (any state): immediate return to the reset values listed above. No pending read is remembered.
- fetch_err clears only on reset.

Test Plan:
- Zero-wait fetch: reset, fetch_en=1, pc_in=0x10, memory returns 0xDEADBEEF on the first WAIT cycle, ir_ready=1. Required: mem_addr=0x010 with mem_read=1 in cycle 1; ir_out=0xDEADBEEF, ir_pc=0x10, ir_valid=1 and a single inc_pc pulse in cycle 2; next ISSUE samples pc_in=0x11.
- Wait states and backpressure: memory ready after 3 cycles, ir_ready held 0 for 4 cycles. Required: mem_read=1 for exactly 4 cycles with mem_addr stable; ir_valid holds 4 cycles with ir_out unchanged; exactly one inc_pc pulse.
- Flush in WAIT: assert flush one cycle before mem_ready. Required: returned data is discarded, ir_valid stays 0, no inc_pc pulse, the next fetch uses the reloaded pc_in=0x40.
- Flush with ir_ready in HOLD: assert flush and ir_ready together. Required: ir_valid=0 next cycle, no extra inc_pc, state returns to ISSUE.
- Timeout: mem_ready never asserted, TIMEOUT=16. Required: fetch_err=1 and mem_read=0 after the 16th WAIT cycle; no further fetches; flush ignored.
- Async reset mid-WAIT: drive clr=0 between clock edges. Required: mem_read, ir_valid and fetch_err go to 0 immediately; after release, fetch restarts from pc_in.
